// File: rtl/image_spike_encoder.sv
// image_spike_encoder
//
// Rate-codes a snapshot of a pixel array into address-event (AER) spikes.
// A rising edge on new_image, seen while idle, captures the image and starts
// N_TIMESTEPS timesteps. Each timestep scans every pixel once through a
// per-pixel integrate-and-fire accumulator. Each firing pixel emits its index
// on a valid/ready spike channel. A one-cycle tick marks the end of each
// timestep, and a one-cycle enc_done marks the end of the image.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   image        IMAGE_SIZE pixels of PIXEL_BITS each (pixel i = image[i])
//   new_image    level flag from the host; its rising edge starts encoding
//   spike_valid  spike event valid
//   spike_addr   index of the spiking pixel
//   spike_ready  downstream accepts the spike
//   tick         one-cycle end-of-timestep pulse
//   busy         encoding in progress
//   enc_done     one-cycle end-of-image pulse
//   spike_count  completed spike transfers since start, saturating
//                (present only when IMG_ENC_SPIKE_COUNT_EN is defined)
//
// Optional feature macro: IMG_ENC_SPIKE_COUNT_EN

module image_spike_encoder #(
    parameter int unsigned IMAGE_SIZE  = 256,
    parameter int unsigned M           = 8,
    parameter int unsigned PIXEL_BITS  = 8,
    parameter int unsigned N_TIMESTEPS = 16,
    parameter int unsigned THRESHOLD   = 256
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] image,
    input  logic                                 new_image,
    output logic                                 spike_valid,
    output logic [M-1:0]                         spike_addr,
    input  logic                                 spike_ready,
    output logic                                 tick,
    output logic                                 busy,
    output logic                                 enc_done
`ifdef IMG_ENC_SPIKE_COUNT_EN
    ,
    output logic [15:0]                          spike_count
`endif
);

    // Two spare bits so acc + pix never overflows.
    localparam int unsigned ACC_W = PIXEL_BITS + 2;
    localparam int unsigned TS_W  = (N_TIMESTEPS > 1) ? $clog2(N_TIMESTEPS) : 1;

    localparam logic [ACC_W-1:0] THRESH   = ACC_W'(THRESHOLD);
    localparam logic [M-1:0]     LAST_IDX = M'(IMAGE_SIZE - 1);
    localparam logic [TS_W-1:0]  LAST_TS  = TS_W'(N_TIMESTEPS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StTick,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic                                  new_image_q;
    logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] pix_q;
    logic [ACC_W-1:0]                      acc_q [IMAGE_SIZE];

    logic [M-1:0]    idx_q, idx_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            spike_valid_q, spike_valid_d;
    logic [M-1:0]    spike_addr_q, spike_addr_d;

    logic             start;
    logic             slot_free;
    logic             xfer;
    logic             snapshot;
    logic             acc_we;
    logic [ACC_W-1:0] cur_acc;
    logic [ACC_W-1:0] sum;
    logic             fire;
    logic [ACC_W-1:0] acc_wdata;

    // Edges are honoured only from idle; later edges are ignored.
    assign start     = new_image && !new_image_q && (state_q == StIdle);
    assign slot_free = !spike_valid_q || spike_ready;
    assign xfer      = spike_valid_q && spike_ready;

    // Integrate-and-fire evaluation of the pixel under the scan index.
    assign cur_acc   = acc_q[idx_q];
    assign sum       = cur_acc + ACC_W'(pix_q[idx_q]);
    assign fire      = (sum >= THRESH);
    assign acc_wdata = fire ? (sum - THRESH) : sum;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ts_d     = ts_q;
        // A pending spike holds until accepted. A completed transfer drops
        // valid unless a new spike is loaded below.
        spike_valid_d = spike_valid_q && !spike_ready;
        spike_addr_d  = spike_addr_q;
        snapshot = 1'b0;
        acc_we   = 1'b0;
        tick     = 1'b0;
        busy     = 1'b0;
        enc_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    snapshot = 1'b1;
                    idx_d    = '0;
                    ts_d     = '0;
                    state_d  = StScan;
                end
            end

            StScan: begin
                busy = 1'b1;
                // Idx and accumulators hold while the output slot is blocked.
                if (slot_free) begin
                    acc_we = 1'b1;
                    if (fire) begin
                        spike_valid_d = 1'b1;
                        spike_addr_d  = idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = StTick;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            StTick: begin
                busy = 1'b1;
                // Drain the last spike of the timestep before ticking.
                if (!spike_valid_q) begin
                    tick = 1'b1;
                    if (ts_q == LAST_TS) begin
                        state_d = StDone;
                    end else begin
                        ts_d    = ts_q + 1'b1;
                        idx_d   = '0;
                        state_d = StScan;
                    end
                end
            end

            StDone: begin
                enc_done = 1'b1;
                state_d  = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            // Reset to 1 so a flag held high through reset is not an edge.
            new_image_q   <= 1'b1;
            idx_q         <= '0;
            ts_q          <= '0;
            spike_valid_q <= 1'b0;
            spike_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            new_image_q   <= new_image;
            idx_q         <= idx_d;
            ts_q          <= ts_d;
            spike_valid_q <= spike_valid_d;
            spike_addr_q  <= spike_addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Accumulators: cleared at start, persist after the image completes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '{default: '0};
        end else if (snapshot) begin
            acc_q <= '{default: '0};
        end else if (acc_we) begin
            acc_q[idx_q] <= acc_wdata;
        end
    end

    // Image snapshot; the live input is ignored until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q <= '0;
        end else if (snapshot) begin
            pix_q <= image;
        end
    end

    assign spike_valid = spike_valid_q;
    assign spike_addr  = spike_addr_q;

`ifdef IMG_ENC_SPIKE_COUNT_EN
    // ------------------------------------------------------------------
    // Saturating count of accepted spikes for the current image
    // ------------------------------------------------------------------
    logic [15:0] spike_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            spike_count_q <= '0;
        end else if (snapshot) begin
            spike_count_q <= '0;
        end else if (xfer && (spike_count_q != 16'hFFFF)) begin
            spike_count_q <= spike_count_q + 16'd1;
        end
    end

    assign spike_count = spike_count_q;
`else
    // Transfer strobe is only consumed by the optional counter.
    logic unused_xfer;
    assign unused_xfer = xfer;
`endif

endmodule

// File: doc/image_spike_encoder.md
Name: image_spike_encoder

Overview:
- Sits directly downstream of the AXI4-Lite slave. Consumes its IMAGE pixel array and NEW_IMAGE flag, and feeds the SNN core.
- On a NEW_IMAGE rising edge, snapshots the image, then rate-codes each pixel into address-event (AER) spikes over N_TIMESTEPS timesteps.
- Uses a deterministic per-pixel integrate-and-fire accumulator.
- Emits spikes on a valid/ready channel, a TICK pulse at the end of each timestep, and an ENC_DONE pulse at the end of the image.

Parameters:
- IMAGE_SIZE, 256, number of pixels; must be ≤ 2^M.
- M, 8, spike address width.
- PIXEL_BITS, 8, pixel width.
- N_TIMESTEPS, 16, timesteps per image; must be ≥ 1.
- THRESHOLD, 256, accumulator firing threshold; must be > 2^PIXEL_BITS − 1.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset.
- IMAGE  in  PIXEL_BITS x IMAGE_SIZE  pixel array.
- NEW_IMAGE  in  1  level flag from the host.
- SPIKE_VALID  out  1  spike event valid.
- SPIKE_ADDR  out  M  index of the spiking pixel.
- SPIKE_READY  in  1  SNN accepts the spike.
- TICK  out  1  one-cycle end-of-timestep pulse.
- BUSY  out  1  encoding in progress.
- ENC_DONE  out  1  one-cycle end-of-image pulse.

Behaviour:
- Single clock CLK. RST is synchronous, active-high.
- Reset state: all outputs 0, state IDLE, accumulators 0, NEW_IMAGE edge register set to 1. A flag held high through reset therefore does not start encoding.
- A RST assertion mid-operation aborts immediately. Any pending spike is dropped and no TICK or ENC_DONE is issued.
- Start detection:
  - The rising edge is NEW_IMAGE=1 with the previous sample 0.
  - It is honoured only in IDLE; edges seen in any other state are ignored.
  - On start, at the next edge: snapshot IMAGE into internal registers, clear all accumulators, pixel index idx=0, timestep ts=0, state SCAN, BUSY=1.
  - Later IMAGE changes have no effect until the next start.
- States are IDLE, SCAN, TICK and DONE.
  - SCAN: one pixel is evaluated per cycle in which the output slot is free. The slot is free when !SPIKE_VALID || SPIKE_READY.
  - SCAN evaluation: sum = acc[idx] + pix[idx], computed in PIXEL_BITS+2 bits so it cannot overflow.
    - If sum ≥ THRESHOLD: acc[idx] = sum − THRESHOLD, load SPIKE_ADDR=idx, and SPIKE_VALID=1 at the next edge.
    - Otherwise acc[idx] = sum and no spike is loaded.
  - SCAN advance: idx increments. After idx = IMAGE_SIZE−1, go to TICK.
  - SCAN stall: if the slot is not free, idx and the accumulators hold.
  - TICK: wait until SPIKE_VALID=0, then assert TICK for exactly 1 cycle. Then:
    - if ts = N_TIMESTEPS−1, go to DONE;
    - otherwise ts++, idx=0, go to SCAN.
  - DONE: ENC_DONE=1 for 1 cycle with BUSY=0, then go to IDLE. Accumulators persist until the next start.
- Spike channel (AXI-style):
  - SPIKE_VALID and SPIKE_ADDR are stable while SPIKE_VALID && !SPIKE_READY.
  - A transfer completes on SPIKE_VALID && SPIKE_READY.
  - If a new spike is loaded in the same cycle as a transfer, SPIKE_VALID stays 1 with the new address.
  - SPIKE_VALID is cleared when a transfer completes and no new spike is loaded.
- Ordering: every spike of timestep t is transferred before TICK of t. TICK never coincides with SPIKE_VALID=1.
- Latency and timing:
  - First spike: SPIKE_VALID is visible at the earliest 2 cycles after the edge-detect cycle.
  - With SPIKE_READY=1, each timestep lasts IMAGE_SIZE+1 cycles if the last pixel does not spike, or IMAGE_SIZE+2 if it does.
- Rate: a pixel with value p fires floor((t+1)·p / THRESHOLD) times over timesteps 0..t.
  - p=0 never fires.
  - With THRESHOLD > p, a pixel fires at most once per timestep.

Optional Feature:
- Macro IMG_ENC_SPIKE_COUNT_EN.
- Defined: adds output port SPIKE_COUNT [15:0].
  - Reset value 0; cleared at start.
  - Increments on each completed spike transfer; saturates at 0xFFFF.
  - Holds its value after ENC_DONE.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- All-zero image, SPIKE_READY=1, N_TIMESTEPS=16 → 0 spikes, 16 TICK pulses 257 cycles apart, 1 ENC_DONE, BUSY then 0.
- Pixel 5=128, pixel 9=255, rest 0, N_TIMESTEPS=4, READY=1:
  - spikes: ts0 none; ts1 addr 5 then 9; ts2 addr 9; ts3 addr 5 then 9;
  - SPIKE_COUNT=5 when IMG_ENC_SPIKE_COUNT_EN is defined.
- All pixels 255, SPIKE_READY low for 10 cycles with a spike pending → SPIKE_ADDR held stable, idx frozen, no spike lost, TICK only after the last addr 255 is accepted.
- Second NEW_IMAGE pulse mid-encoding, and IMAGE changed to all 0 mid-run → ignored; spike stream identical to an undisturbed run.
- RST pulsed during ts2 with SPIKE_VALID=1 → next cycle all outputs 0.
  - NEW_IMAGE still high → no restart.
  - Low then high → restart from ts0 with cleared accumulators.
- Last pixel (IMAGE_SIZE−1) fires in the final timestep → SPIKE_VALID, then TICK on the next cycle, then ENC_DONE the cycle after.
